// File: rtl/mpu_pkg.sv
// Shared types and constants for the MPU elementwise ALU.
//   op_t    : operation encoding driven on the 2-bit op port
//   state_t : sequencing FSM states
//   ceil_div: beat count for a matrix of n elements processed d per cycle
package mpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MAX  = 2'b10,
    OP_COPY = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIM    = 5;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/mpu_lane.sv
// Single-element combinational ALU lane.
//   a, b     : signed operands
//   op       : ADD / SUB (a-b) / signed MAX / COPY (a)
//   saturate : clamp ADD/SUB results instead of wrapping
//   y        : element result
//   ovf      : ADD/SUB result left the signed DATA_W range (either mode)
module mpu_lane
  import mpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  op_t                      op,
  input  logic                     saturate,
  output logic signed [DATA_W-1:0] y,
  output logic                     ovf
);

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  // The wide sum overflowed when its top two bits disagree; the top bit
  // then tells the true sign, which picks the clamp rail.
  function automatic logic signed [DATA_W-1:0] sat_or_wrap(
    input logic signed [DATA_W:0] wide,
    input logic                   sat
  );
    if (sat && (wide[DATA_W] != wide[DATA_W-1])) begin
      return wide[DATA_W] ? MIN_V : MAX_V;
    end
    return wide[DATA_W-1:0];
  endfunction

  logic signed [DATA_W:0] a_x;
  logic signed [DATA_W:0] b_x;
  logic signed [DATA_W:0] wide;

  always_comb begin
    a_x  = {a[DATA_W-1], a};
    b_x  = {b[DATA_W-1], b};
    wide = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    y    = a;
    ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        y   = sat_or_wrap(wide, saturate);
        ovf = (wide[DATA_W] != wide[DATA_W-1]);
      end
      OP_MAX:  y = (a >= b) ? a : b;
      OP_COPY: y = a;
    endcase
  end

endmodule

// File: rtl/mpu_elementwise_alu.sv
// Multi-cycle elementwise matrix ALU.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted in IDLE or DONE, ignored in RUN
//   op         : 00 ADD, 01 SUB, 10 MAX, 11 COPY
//   saturate   : clamp ADD/SUB instead of wrapping
//   matrix_a/b : DIM x DIM signed elements, row-major, element idx at
//                bits [idx*DATA_W +: DATA_W]
//   busy       : high while beats are being computed
//   done       : one-cycle pulse once result is final
//   result     : registered result matrix, same layout
//   overflow   : sticky ADD/SUB overflow for the current operation
// Operands are captured on the accepting edge; LANES elements are computed
// per beat, and the final beat may be partial.
module mpu_elementwise_alu
  import mpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM    = DEF_DIM,
  parameter int LANES  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic                        saturate,
  input  logic [DIM*DIM*DATA_W-1:0]   matrix_a,
  input  logic [DIM*DIM*DATA_W-1:0]   matrix_b,
  output logic                        busy,
  output logic                        done,
  output logic [DIM*DIM*DATA_W-1:0]   result,
  output logic                        overflow
);

  localparam int TOTAL    = DIM * DIM;
  localparam int MAT_W    = TOTAL * DATA_W;
  localparam int BEATS    = ceil_div(TOTAL, LANES);
  localparam int LAST_IDX = (BEATS - 1) * LANES;
  localparam int IDX_W    = $clog2(TOTAL + LANES + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               overflow_q, overflow_d;
  logic [MAT_W-1:0]   result_q, result_d;
  logic [MAT_W-1:0]   a_q, a_d;
  logic [MAT_W-1:0]   b_q, b_d;
  op_t                op_q, op_d;
  logic               sat_q, sat_d;

  logic               accept;

  logic signed [DATA_W-1:0] lane_a [LANES];
  logic signed [DATA_W-1:0] lane_b [LANES];
  logic signed [DATA_W-1:0] lane_y [LANES];
  logic [LANES-1:0]         lane_ovf;
  logic [LANES-1:0]         lane_vld;

  assign accept = start && (state_q != ST_RUN);

  // Operand fetch: lane k works on element idx+k; lanes past the end of
  // the matrix on a partial beat see zeros and are flagged invalid.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_a[k]   = '0;
      lane_b[k]   = '0;
      lane_vld[k] = 1'b0;
      for (int t = 0; t < TOTAL; t++) begin
        if (int'(idx_q) + k == t) begin
          lane_a[k]   = a_q[t*DATA_W +: DATA_W];
          lane_b[k]   = b_q[t*DATA_W +: DATA_W];
          lane_vld[k] = 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mpu_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .a       (lane_a[k]),
      .b       (lane_b[k]),
      .op      (op_q),
      .saturate(sat_q),
      .y       (lane_y[k]),
      .ovf     (lane_ovf[k])
    );
  end

  // Control and writeback.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    result_d   = result_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    sat_d      = sat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        for (int t = 0; t < TOTAL; t++) begin
          for (int k = 0; k < LANES; k++) begin
            if (int'(idx_q) + k == t) result_d[t*DATA_W +: DATA_W] = lane_y[k];
          end
        end
        overflow_d = overflow_q | (|(lane_ovf & lane_vld));
        idx_d      = idx_q + IDX_W'(LANES);
        if (int'(idx_q) == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      a_d        = matrix_a;
      b_d        = matrix_b;
      op_d       = op_t'(op);
      sat_d      = saturate;
      idx_d      = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      result_q   <= result_d;
    end
  end

  // Captured operands carry no reset; they are only read in RUN, which is
  // always entered through a capture.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    op_q  <= op_d;
    sat_q <= sat_d;
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mpu_elementwise_alu.sv
module tb_mpu_elementwise_alu;

  localparam int DW  = 8;
  localparam int DIM = 5;
  localparam int TOT = DIM * DIM;
  localparam int MW  = TOT * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start0, start4;
  logic [1:0]    op;
  logic          saturate;
  logic [MW-1:0] matrix_a, matrix_b;
  logic          busy0, done0, ovf0;
  logic          busy4, done4, ovf4;
  logic [MW-1:0] result0, result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpu_elementwise_alu #(.DATA_W(DW), .DIM(DIM), .LANES(5)) dut (
    .clk(clk), .rst(rst), .start(start0), .op(op), .saturate(saturate),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .busy(busy0), .done(done0), .result(result0), .overflow(ovf0)
  );

  mpu_elementwise_alu #(.DATA_W(DW), .DIM(DIM), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .saturate(saturate),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .busy(busy4), .done(done4), .result(result4), .overflow(ovf4)
  );

  typedef struct {
    logic [1:0] op;
    bit         sat;
    bit         a_idx;   // a(t) = t + a when set, else all a
    int         a;
    int         b;
    bit         e_idx;   // expected(t) = t + e when set, else all e
    int         e;
    bit         e_ovf;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [MW-1:0] build(input bit idx_mode, input int v);
    logic [MW-1:0] m;
    m = '0;
    for (int t = 0; t < TOT; t++) m[t*DW +: DW] = DW'(idx_mode ? t + v : v);
    return m;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? busy0 : busy4;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 0) ? done0 : done4;
  endfunction
  function automatic logic get_ovf(input int w);
    return (w == 0) ? ovf0 : ovf4;
  endfunction
  function automatic logic [MW-1:0] get_result(input int w);
    return (w == 0) ? result0 : result4;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_result(input string name, input logic [MW-1:0] r,
                            input bit idx_mode, input int e);
    int nbad, bad_t, bad_act, bad_exp, ex, act;
    nbad = 0; bad_t = -1; bad_act = 0; bad_exp = 0;
    for (int t = 0; t < TOT; t++) begin
      ex  = idx_mode ? t + e : e;
      act = int'($signed(r[t*DW +: DW]));
      if (act != ex) begin
        if (nbad == 0) begin bad_t = t; bad_act = act; bad_exp = ex; end
        nbad++;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL %s result: %0d elems wrong, elem %0d got %0d expected %0d",
               name, nbad, bad_t, bad_act, bad_exp);
    end
  endtask

  task automatic pulse_start(input int w);
    @(negedge clk);
    if (w == 0) start0 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic run_vec(input int w, input int idx, input int beats);
    int    done_cyc, ndone, busy_bad;
    string tag;
    tag = $sformatf("L%0d v%0d", (w == 0) ? 5 : 4, idx);
    op       = vecs[idx].op;
    saturate = vecs[idx].sat;
    matrix_a = build(vecs[idx].a_idx, vecs[idx].a);
    matrix_b = build(1'b0, vecs[idx].b);
    pulse_start(w);
    done_cyc = -1; ndone = 0; busy_bad = 0;
    for (int c = 1; c <= beats + 3; c++) begin
      if (get_busy(w) != (c <= beats)) busy_bad++;
      if (get_done(w)) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(negedge clk);
    end
    chk({tag, " done cycle"}, done_cyc, beats + 1);
    chk({tag, " done count"}, ndone, 1);
    chk({tag, " busy wrong cycles"}, busy_bad, 0);
    chk_result(tag, get_result(w), vecs[idx].e_idx, vecs[idx].e);
    chk({tag, " overflow"}, int'(get_ovf(w)), int'(vecs[idx].e_ovf));
  endtask

  initial begin
    int first_done, second_done, ndone, busy_late, nz;

    vecs[0]  = '{2'b00, 1'b0, 1'b1, 0,    1,   1'b1, 1,    1'b0};
    vecs[1]  = '{2'b00, 1'b0, 1'b0, 100,  50,  1'b0, -106, 1'b1};
    vecs[2]  = '{2'b00, 1'b1, 1'b0, 100,  50,  1'b0, 127,  1'b1};
    vecs[3]  = '{2'b01, 1'b1, 1'b0, -100, 100, 1'b0, -128, 1'b1};
    vecs[4]  = '{2'b01, 1'b0, 1'b0, 5,    3,   1'b0, 2,    1'b0};
    vecs[5]  = '{2'b10, 1'b0, 1'b0, -3,   2,   1'b0, 2,    1'b0};
    vecs[6]  = '{2'b10, 1'b0, 1'b0, 7,    7,   1'b0, 7,    1'b0};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, -9,   100, 1'b0, -9,   1'b0};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, -100, 100, 1'b0, 56,   1'b1};
    vecs[9]  = '{2'b10, 1'b0, 1'b0, -5,   -100, 1'b0, -5,  1'b0};
    vecs[10] = '{2'b00, 1'b1, 1'b0, -128, -1,  1'b0, -128, 1'b1};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 127,  0,   1'b0, 127,  1'b0};

    rst = 1'b1; start0 = 1'b0; start4 = 1'b0;
    op = 2'b00; saturate = 1'b0; matrix_a = '0; matrix_b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset overflow", int'(ovf0), 0);
    chk_result("reset", result0, 1'b0, 0);
    chk("reset busy L4", int'(busy4), 0);
    chk_result("reset L4", result4, 1'b0, 0);
    rst = 1'b0;

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 12; i++) run_vec(w, i, (w == 0) ? 5 : 7);
    end

    // start during RUN is ignored; inputs changed after capture are not used
    op = 2'b00; saturate = 1'b0;
    matrix_a = build(1'b0, 1); matrix_b = build(1'b0, 1);
    pulse_start(0);
    first_done = -1; ndone = 0; busy_late = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done0) begin ndone++; if (first_done < 0) first_done = c; end
      if (c >= 7 && busy0) busy_late++;
      if (c == 2) begin
        start0 = 1'b1; op = 2'b11; matrix_a = build(1'b0, 50);
      end else begin
        start0 = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignored start done cycle", first_done, 6);
    chk("ignored start done count", ndone, 1);
    chk("ignored start busy after done", busy_late, 0);
    chk_result("ignored start", result0, 1'b0, 2);

    // start in the DONE cycle runs back-to-back
    op = 2'b00; saturate = 1'b0;
    matrix_a = build(1'b0, 1); matrix_b = build(1'b0, 1);
    pulse_start(0);
    first_done = -1; second_done = -1; busy_late = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done0) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      if (c >= 7 && c <= 11 && !busy0) busy_late++;
      if (c == 6) begin
        start0 = 1'b1; op = 2'b01; matrix_a = build(1'b0, 10); matrix_b = build(1'b0, 3);
      end else begin
        start0 = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b first done", first_done, 6);
    chk("b2b second done", second_done, 12);
    chk("b2b busy gaps", busy_late, 0);
    chk_result("b2b", result0, 1'b0, 7);

    // reset at RUN beat 2 aborts
    op = 2'b00; saturate = 1'b0;
    matrix_a = build(1'b0, 100); matrix_b = build(1'b0, 50);
    pulse_start(0);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) rst = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", int'(busy0), 0);
    chk("abort overflow", int'(ovf0), 0);
    chk_result("abort", result0, 1'b0, 0);
    ndone = 0; busy_late = 0;
    for (int c = 0; c < 8; c++) begin
      if (done0) ndone++;
      if (busy0) busy_late++;
      @(negedge clk);
    end
    chk("abort done pulses", ndone, 0);
    chk("abort busy after", busy_late, 0);
    nz = 0;
    for (int t = 0; t < TOT; t++) if (result0[t*DW +: DW] != '0) nz++;
    chk("abort result nonzero elems", nz, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpu_elementwise_alu.md
Name: mpu_elementwise_alu

Overview:
- Multi-cycle elementwise matrix ALU for the MPU. Generalises the fixed 5x5, 8-bit, add-only combinational adder.
- Parametrised in data width, matrix dimension and lanes (elements processed per cycle).
- Supports add, subtract, signed max and copy, with optional signed saturation and a sticky overflow flag.
- Driven by the MPU controller through a start/busy/done handshake; the result is held in a register for the next stage.

Parameters:
- DATA_W, 8, element width in bits; elements are signed two's complement.
- DIM, 5, matrix is DIM x DIM.
- LANES, 5, elements computed per cycle; 1 <= LANES <= DIM*DIM; need not divide DIM*DIM.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled in IDLE or DONE.
- op  in  2  00 ADD, 01 SUB (a-b), 10 MAX (signed), 11 COPY (a).
- saturate  in  1  1 = clamp ADD/SUB results to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; 0 = wrap.
- matrix_a  in  DIM*DIM*DATA_W  flattened row-major; element (i,j) at index i*DIM+j, bits [idx*DATA_W +: DATA_W].
- matrix_b  in  DIM*DIM*DATA_W  same layout as matrix_a.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result is final.
- result  out  DIM*DIM*DATA_W  registered result, same layout.
- overflow  out  1  sticky: any ADD/SUB element overflowed during the current operation.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, overflow=0, idx=0.
- Reset mid-operation aborts it immediately. No done pulse follows; result reads 0.
- TOTAL=DIM*DIM; BEATS=ceil(TOTAL/LANES).
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - capture matrix_a, matrix_b, op and saturate into internal registers;
  - idx=0, overflow=0, go to RUN.
  - Inputs may change after the capture edge.
- RUN, each cycle:
  - lanes k=0..LANES-1 compute element idx+k if idx+k < TOTAL and write it into result;
  - lanes with idx+k >= TOTAL (last partial beat) write nothing;
  - idx += LANES;
  - after beat BEATS-1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while in DONE is accepted: same capture as IDLE, go directly to RUN (back-to-back). done still pulses in that cycle.
- start while in RUN is ignored; there is no queueing.
- Latency: start sampled at edge E. busy is high for cycles E+1..E+BEATS. done is high in cycle E+BEATS+1. Defaults give 5 beats, with done in cycle 6.
- result elements not yet overwritten during RUN keep their previous values. result holds after done until the next operation writes it.
- Arithmetic per element, on a DATA_W+1 bit intermediate:
  - ADD/SUB overflow when the intermediate is outside the signed DATA_W range;
  - saturate=1 clamps to the max or min value;
  - saturate=0 keeps the low DATA_W bits;
  - overflow is set whenever any element overflows, in either saturate mode.
- MAX: signed compare; a is chosen on a tie; never overflows.
- COPY: result=a; never overflows.
- overflow clears on accepted start and is stable from done until the next start.

Decomposition:
- Package mpu_pkg holds:
  - op_t enum (OP_ADD, OP_SUB, OP_MAX, OP_COPY);
  - fsm state enum;
  - default DATA_W and DIM constants;
  - function for ceil-div BEATS.
- Sub-module mpu_lane: combinational single-element ALU.
  - Inputs: a, b, op, saturate.
  - Outputs: y, ovf.
  - Instantiated LANES times via generate.
- Top block holds the FSM, idx counter, operand/result registers and the lane mux/demux.

Test Plan:
- Defaults, ADD: a(i,j)=i*5+j, b all 1, saturate=0 -> done in cycle 6; result(i,j)=i*5+j+1; overflow=0; busy high cycles 1-5.
- ADD wrap vs saturate: a all 100, b all 50. saturate=0 -> all elements 0x96 (-106), overflow=1. saturate=1 -> all 127, overflow=1.
- SUB saturation: a all -100, b all 100, saturate=1 -> all -128, overflow=1. Then a=5, b=3 -> all 2 and overflow clears to 0.
- MAX/COPY: a=-3, b=2 -> MAX gives 2. a=7, b=7 -> MAX gives 7. COPY gives a regardless of b; overflow=0.
- LANES=4, DIM=5 (partial beat): BEATS=7; done in cycle 8; element 24 is written on beat 6 by lane 0 only; all 25 elements correct.
- Control: start during RUN is ignored, with no extra done. start in the DONE cycle gives a back-to-back run with done 6 cycles later. rst at RUN beat 2 -> next cycle busy=0, result=0, no done pulse.
